dm_sba_ext: RTL and testbench



---
 rtl/dm_sba_ext.sv | 218 +++++++++++++++++++++
 tb/tb_dm_sba_ext.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_ext.sv
// System-bus-access engine for the debug module: size/alignment pre-checks, bus-error capture
// and a per-access timeout, with results reported through the sberror encoding.
module dm_sba_ext #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic                  sbreadondata_i,
  input  logic [2:0]            sbaccess_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_write_valid_i,
  input  logic                  sbdata_read_valid_i,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic                  master_r_err_i
);
  localparam int unsigned NumBytes = BusWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned CntW     = $clog2(TimeoutCycles);
  localparam logic [2:0]  MaxSize  = 3'(OffW);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [BusWidth-1:0] addr_q, addr_d, rdata_q, rdata_d;
  logic [BusWidth-1:0] add_q, add_d, wdata_q, wdata_d;
  logic [NumBytes-1:0] be_q, be_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [OffW-1:0]     off_q, off_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                drop_q, drop_d, discard_q, discard_d;
  logic                data_valid_q, data_valid_d, err_valid_q, err_valid_d;
  logic [2:0]          err_q, err_d;

  logic                trig_wr, trig_rd_addr, trig_rd_data, trig;
  logic [BusWidth-1:0] trig_addr, wdata_calc, rd_shift, rd_calc;
  logic [OffW-1:0]     trig_off;
  logic [2:0]          align_mask;
  logic                size_err, align_err, keep;
  logic [NumBytes-1:0] be_calc;

  always_comb begin
    trig_wr      = sbdata_write_valid_i;
    trig_rd_addr = sbaddress_write_valid_i && sbreadonaddr_i;
    trig_rd_data = sbdata_read_valid_i && sbreadondata_i;
    trig         = (state_q == StIdle) && !drop_q && dmactive_i &&
                   (trig_wr || trig_rd_addr || trig_rd_data);
    // A read-on-address uses the address being written this cycle.
    trig_addr    = (!trig_wr && trig_rd_addr) ? sbaddress_i : addr_q;
    trig_off     = trig_addr[OffW-1:0];
    align_mask   = 3'((4'd1 << sbaccess_i[1:0]) - 4'd1);
    size_err     = sbaccess_i > MaxSize;
    align_err    = |(trig_addr[2:0] & align_mask);
    rd_shift     = master_r_rdata_i >> {off_q, 3'b000};
    for (int unsigned i = 0; i < NumBytes; i++) begin
      be_calc[i] = (i >= 32'(trig_off)) &&
                   (i < 32'(trig_off) + (32'd1 << sbaccess_i[1:0]));
      wdata_calc[8*i +: 8] = sbdata_i[8*(i & ((32'd1 << sbaccess_i[1:0]) - 32'd1)) +: 8];
      rd_calc[8*i +: 8]    = (i < (32'd1 << size_q)) ? rd_shift[8*i +: 8] : 8'h00;
    end
    keep = dmactive_i && !discard_q;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    add_d        = add_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    size_d       = size_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    discard_d    = discard_q;
    data_valid_d = 1'b0;
    err_valid_d  = 1'b0;
    err_d        = err_q;
    // Losing dmactive mid-access poisons the result even if it comes back.
    if (state_q != StIdle && !dmactive_i) discard_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (drop_q && master_r_valid_i) drop_d = 1'b0;
        if (trig) begin
          if (size_err || align_err) begin
            err_valid_d = 1'b1;
            err_d       = size_err ? 3'd4 : 3'd3;
          end else begin
            state_d   = StReq;
            cnt_d     = '0;
            discard_d = 1'b0;
            add_d     = trig_addr & ~BusWidth'(NumBytes - 1);
            we_d      = trig_wr;
            wdata_d   = wdata_calc;
            be_d      = be_calc;
            size_d    = sbaccess_i[1:0];
            off_d     = trig_off;
          end
        end
      end
      StReq: begin
        if (master_gnt_i) begin
          state_d = StWait;
          cnt_d   = cnt_q + 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          if (keep) begin
            err_valid_d = 1'b1;
            err_d       = 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (master_r_valid_i) begin
          state_d = StIdle;
          if (keep) begin
            if (master_r_err_i) begin
              err_valid_d = 1'b1;
              err_d       = 3'd2;
            end else begin
              if (!we_q) begin
                rdata_d      = rd_calc;
                data_valid_d = 1'b1;
              end
              if (sbautoincrement_i) addr_d = addr_q + (BusWidth'(1) << size_q);
            end
          end
        end else if (cnt_q == CntLast) begin
          // The granted response is still owed; swallow it when it shows up.
          state_d = StIdle;
          drop_d  = 1'b1;
          if (keep) begin
            err_valid_d = 1'b1;
            err_d       = 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (sbaddress_write_valid_i) addr_d = sbaddress_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rdata_q      <= '0;
      add_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
      discard_q    <= 1'b0;
      data_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      add_q        <= add_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      size_q       <= size_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      discard_q    <= discard_d;
      data_valid_q <= data_valid_d;
      err_valid_q  <= err_valid_d;
      err_q        <= err_d;
    end
  end

  assign sbaddress_o     = addr_q;
  assign sbdata_o        = rdata_q;
  assign sbdata_valid_o  = data_valid_q;
  assign sbbusy_o        = (state_q != StIdle) || drop_q;
  assign sberror_valid_o = err_valid_q;
  assign sberror_o       = err_q;
  assign master_req_o    = (state_q == StReq);
  assign master_add_o    = add_q;
  assign master_we_o     = we_q;
  assign master_wdata_o  = wdata_q;
  assign master_be_o     = be_q;

endmodule

// File: tb/tb_dm_sba_ext.sv
// Bench for dm_sba_ext: directed corner cases plus random accesses against an arithmetic model,
// on a 32-bit instance (short timeout) and a 64-bit instance.
module tb_dm_sba_ext;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic dmactive_i;

  logic [31:0] sbaddress_i, sbdata_i, master_r_rdata_i;
  logic        sbaddress_write_valid_i, sbreadonaddr_i, sbautoincrement_i, sbreadondata_i;
  logic        sbdata_write_valid_i, sbdata_read_valid_i;
  logic        master_gnt_i, master_r_valid_i, master_r_err_i;
  logic [2:0]  sbaccess_i;
  logic [31:0] sbaddress_o, sbdata_o, master_add_o, master_wdata_o;
  logic        sbdata_valid_o, sbbusy_o, sberror_valid_o, master_req_o, master_we_o;
  logic [2:0]  sberror_o;
  logic [3:0]  master_be_o;

  logic [63:0] w_sbaddress_i, w_sbdata_i, w_master_r_rdata_i;
  logic        w_sbaddress_write_valid_i, w_sbdata_write_valid_i;
  logic        w_master_gnt_i, w_master_r_valid_i;
  logic [2:0]  w_sbaccess_i;
  logic [63:0] w_sbaddress_o, w_sbdata_o, w_master_add_o, w_master_wdata_o;
  logic        w_sbdata_valid_o, w_sbbusy_o, w_sberror_valid_o, w_master_req_o, w_master_we_o;
  logic [2:0]  w_sberror_o;
  logic [7:0]  w_master_be_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  dm_sba_ext #(.BusWidth(32), .TimeoutCycles(8)) u_dut32 (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
    .sbaddress_i(sbaddress_i), .sbaddress_write_valid_i(sbaddress_write_valid_i),
    .sbaddress_o(sbaddress_o), .sbreadonaddr_i(sbreadonaddr_i),
    .sbautoincrement_i(sbautoincrement_i), .sbreadondata_i(sbreadondata_i),
    .sbaccess_i(sbaccess_i), .sbdata_i(sbdata_i), .sbdata_write_valid_i(sbdata_write_valid_i),
    .sbdata_read_valid_i(sbdata_read_valid_i), .sbdata_o(sbdata_o),
    .sbdata_valid_o(sbdata_valid_o), .sbbusy_o(sbbusy_o), .sberror_valid_o(sberror_valid_o),
    .sberror_o(sberror_o), .master_req_o(master_req_o), .master_add_o(master_add_o),
    .master_we_o(master_we_o), .master_wdata_o(master_wdata_o), .master_be_o(master_be_o),
    .master_gnt_i(master_gnt_i), .master_r_valid_i(master_r_valid_i),
    .master_r_rdata_i(master_r_rdata_i), .master_r_err_i(master_r_err_i)
  );

  dm_sba_ext #(.BusWidth(64), .TimeoutCycles(16)) u_dut64 (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
    .sbaddress_i(w_sbaddress_i), .sbaddress_write_valid_i(w_sbaddress_write_valid_i),
    .sbaddress_o(w_sbaddress_o), .sbreadonaddr_i(1'b0), .sbautoincrement_i(1'b0),
    .sbreadondata_i(1'b0), .sbaccess_i(w_sbaccess_i), .sbdata_i(w_sbdata_i),
    .sbdata_write_valid_i(w_sbdata_write_valid_i), .sbdata_read_valid_i(1'b0),
    .sbdata_o(w_sbdata_o), .sbdata_valid_o(w_sbdata_valid_o), .sbbusy_o(w_sbbusy_o),
    .sberror_valid_o(w_sberror_valid_o), .sberror_o(w_sberror_o),
    .master_req_o(w_master_req_o), .master_add_o(w_master_add_o), .master_we_o(w_master_we_o),
    .master_wdata_o(w_master_wdata_o), .master_be_o(w_master_be_o),
    .master_gnt_i(w_master_gnt_i), .master_r_valid_i(w_master_r_valid_i),
    .master_r_rdata_i(w_master_r_rdata_i), .master_r_err_i(1'b0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // kind: 0 write, 1 read-on-address, 2 read-on-data (address preloaded).
  task automatic do_access(input int kind, input logic [31:0] a, input int s,
                           input logic [31:0] wd, input logic ai, input int gd, input int rd,
                           input logic rerr, input logic [31:0] rdata);
    int          nb, off;
    logic [2:0]  ecode;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic [3:0]  exp_be;
    nb     = 1 << s;
    off    = int'(a % 4);
    ecode  = (s > 2) ? 3'd4 : ((a % nb) != 0) ? 3'd3 : 3'd0;
    exp_be = 4'(((32'd1 << nb) - 32'd1) << off);
    exp_wd = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
    exp_rd = 32'((64'(rdata) >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1));
    exp_addr = (ecode == 0 && ai && !rerr) ? a + 32'(nb) : a;
    sbaccess_i = 3'(s);
    sbautoincrement_i = ai;
    if (kind != 1) begin
      sbaddress_i = a;
      sbaddress_write_valid_i = 1'b1;
      sbreadonaddr_i = 1'b0;
      tick();
      sbaddress_write_valid_i = 1'b0;
    end
    case (kind)
      0: begin sbdata_i = wd; sbdata_write_valid_i = 1'b1; end
      1: begin sbaddress_i = a; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1; end
      default: begin sbdata_read_valid_i = 1'b1; sbreadondata_i = 1'b1; end
    endcase
    tick();
    sbdata_write_valid_i = 1'b0; sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    sbdata_read_valid_i = 1'b0; sbreadondata_i = 1'b0;
    if (ecode != 0) begin
      check_eq("precheck_err_valid", 64'(sberror_valid_o), 64'd1);
      check_eq("precheck_err_code", 64'(sberror_o), 64'(ecode));
      check_eq("precheck_no_req", 64'(master_req_o), 64'd0);
      check_eq("precheck_no_busy", 64'(sbbusy_o), 64'd0);
    end else begin
      check_eq("req", 64'(master_req_o), 64'd1);
      check_eq("busy_req", 64'(sbbusy_o), 64'd1);
      check_eq("add", 64'(master_add_o), 64'(a & ~32'd3));
      check_eq("be", 64'(master_be_o), 64'(exp_be));
      check_eq("we", 64'(master_we_o), 64'(kind == 0));
      if (kind == 0) check_eq("wdata", 64'(master_wdata_o), 64'(exp_wd));
      repeat (gd) tick();
      check_eq("req_held", 64'(master_req_o), 64'd1);
      master_gnt_i = 1'b1;
      tick();
      master_gnt_i = 1'b0;
      check_eq("busy_wait", 64'(sbbusy_o), 64'd1);
      check_eq("req_drop", 64'(master_req_o), 64'd0);
      repeat (rd) tick();
      master_r_valid_i = 1'b1; master_r_err_i = rerr; master_r_rdata_i = rdata;
      tick();
      master_r_valid_i = 1'b0; master_r_err_i = 1'b0;
      check_eq("busy_done", 64'(sbbusy_o), 64'd0);
      check_eq("err_valid", 64'(sberror_valid_o), 64'(rerr));
      if (rerr) check_eq("err_code_bus", 64'(sberror_o), 64'd2);
      check_eq("data_valid", 64'(sbdata_valid_o), 64'(kind != 0 && !rerr));
      if (kind != 0 && !rerr) check_eq("rdata", 64'(sbdata_o), 64'(exp_rd));
    end
    check_eq("address", 64'(sbaddress_o), 64'(exp_addr));
  endtask

  initial begin
    int          kind, s, gd, rd;
    logic [31:0] a;
    logic        rerr;
    rst_ni = 1'b0; dmactive_i = 1'b1;
    sbaddress_i = '0; sbdata_i = '0; master_r_rdata_i = '0; sbaccess_i = '0;
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0; sbautoincrement_i = 1'b0;
    sbreadondata_i = 1'b0; sbdata_write_valid_i = 1'b0; sbdata_read_valid_i = 1'b0;
    master_gnt_i = 1'b0; master_r_valid_i = 1'b0; master_r_err_i = 1'b0;
    w_sbaddress_i = '0; w_sbdata_i = '0; w_master_r_rdata_i = '0; w_sbaccess_i = '0;
    w_sbaddress_write_valid_i = 1'b0; w_sbdata_write_valid_i = 1'b0;
    w_master_gnt_i = 1'b0; w_master_r_valid_i = 1'b0;
    repeat (3) tick();
    check_eq("rst_addr", 64'(sbaddress_o), 64'd0);
    check_eq("rst_data", 64'(sbdata_o), 64'd0);
    check_eq("rst_req", 64'(master_req_o), 64'd0);
    check_eq("rst_be", 64'(master_be_o), 64'd0);
    check_eq("rst_busy", 64'(sbbusy_o), 64'd0);
    check_eq("rst_err", 64'({sberror_valid_o, sberror_o, sbdata_valid_o}), 64'd0);
    rst_ni = 1'b1;
    tick();

    do_access(1, 32'h1000_0002, 1, 32'h0, 1'b1, 0, 0, 1'b0, 32'hBEEF_1234);
    check_eq("plan_rdata", 64'(sbdata_o), 64'h0000_BEEF);
    check_eq("plan_autoinc", 64'(sbaddress_o), 64'h1000_0004);
    do_access(1, 32'h0000_0003, 2, 32'h0, 1'b0, 0, 0, 1'b0, 32'h0);
    do_access(0, 32'h0000_0100, 3, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0, 32'h0);
    do_access(1, 32'h0000_2000, 2, 32'h0, 1'b1, 1, 1, 1'b1, 32'h1234_5678);
    do_access(1, 32'hFFFF_FFFC, 2, 32'h0, 1'b1, 0, 0, 1'b0, 32'hA5A5_5A5A);
    check_eq("wrap", 64'(sbaddress_o), 64'd0);

    // Grant withheld: timeout raised eight cycles after req rises.
    sbaccess_i = 3'd2; sbautoincrement_i = 1'b1;
    sbaddress_i = 32'h40; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    check_eq("to_req_rise", 64'(master_req_o), 64'd1);
    repeat (7) tick();
    check_eq("to_req_last", 64'(master_req_o), 64'd1);
    check_eq("to_no_err_early", 64'(sberror_valid_o), 64'd0);
    tick();
    check_eq("to_err_valid", 64'(sberror_valid_o), 64'd1);
    check_eq("to_err_code", 64'(sberror_o), 64'd1);
    check_eq("to_req_drop", 64'(master_req_o), 64'd0);
    check_eq("to_addr_kept", 64'(sbaddress_o), 64'h40);

    // Timeout in WAIT, then a late response that must be swallowed.
    sbaddress_i = 32'h80; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    master_gnt_i = 1'b1;
    tick();
    master_gnt_i = 1'b0;
    repeat (6) tick();
    check_eq("tow_no_err_early", 64'(sberror_valid_o), 64'd0);
    tick();
    check_eq("tow_err_code", 64'({sberror_valid_o, sberror_o}), 64'({1'b1, 3'd1}));
    check_eq("tow_busy_drop", 64'(sbbusy_o), 64'd1);
    master_r_valid_i = 1'b1; master_r_rdata_i = $urandom;
    tick();
    master_r_valid_i = 1'b0;
    check_eq("late_no_data", 64'(sbdata_valid_o), 64'd0);
    check_eq("late_busy_clr", 64'(sbbusy_o), 64'd0);
    do_access(1, 32'h0000_0200, 2, 32'h0, 1'b0, 0, 0, 1'b0, 32'h0BAD_CAFE);

    // dmactive low blocks the trigger but not the address update.
    dmactive_i = 1'b0;
    sbaddress_i = 32'h300; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0; dmactive_i = 1'b1;
    check_eq("inactive_no_req", 64'(master_req_o), 64'd0);
    check_eq("inactive_addr", 64'(sbaddress_o), 64'h300);

    // Reset while in WAIT.
    sbaddress_i = 32'h400; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    master_gnt_i = 1'b1;
    tick();
    master_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(sbbusy_o), 64'd0);
    check_eq("mid_rst_req_be", 64'({master_req_o, master_be_o}), 64'd0);
    check_eq("mid_rst_addr_data", 64'({sbaddress_o, sbdata_o}), 64'd0);
    check_eq("mid_rst_add", 64'(master_add_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    master_r_valid_i = 1'b1;
    tick();
    master_r_valid_i = 1'b0;
    check_eq("post_rst_no_data", 64'(sbdata_valid_o), 64'd0);
    check_eq("post_rst_idle", 64'(sbbusy_o), 64'd0);

    // 64-bit double-word write.
    w_sbaddress_i = 64'h8; w_sbaddress_write_valid_i = 1'b1;
    tick();
    w_sbaddress_write_valid_i = 1'b0;
    w_sbdata_i = 64'h1122_3344_5566_7788; w_sbaccess_i = 3'd3; w_sbdata_write_valid_i = 1'b1;
    tick();
    w_sbdata_write_valid_i = 1'b0;
    check_eq("w64_req", 64'(w_master_req_o), 64'd1);
    check_eq("w64_be", 64'(w_master_be_o), 64'hFF);
    check_eq("w64_add", w_master_add_o, 64'h8);
    check_eq("w64_wdata", w_master_wdata_o, 64'h1122_3344_5566_7788);
    check_eq("w64_we_busy", 64'({w_master_we_o, w_sbbusy_o}), 64'd3);
    w_master_gnt_i = 1'b1;
    tick();
    w_master_gnt_i = 1'b0;
    check_eq("w64_single_req", 64'(w_master_req_o), 64'd0);
    check_eq("w64_busy_wait", 64'(w_sbbusy_o), 64'd1);
    w_master_r_valid_i = 1'b1;
    tick();
    w_master_r_valid_i = 1'b0;
    check_eq("w64_done", 64'({w_sbbusy_o, w_sberror_valid_o, w_sbdata_valid_o}), 64'd0);

    for (int k = 0; k < 60; k++) begin
      kind = int'($urandom_range(0, 2));
      s    = int'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
      rerr = ($urandom_range(0, 7) == 0);
      gd   = int'($urandom_range(0, 2));
      rd   = int'($urandom_range(0, 2));
      do_access(kind, a, s, $urandom, 1'($urandom_range(0, 1)), gd, rd, rerr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
